// File: rtl/pc_unit_pkg.sv
// -----------------------------------------------------------------------------
// pc_unit_pkg
// Shared encodings for the program-counter stage and its return-address stack.
//   - PC_Src selector encodings (next-PC source)
//   - BRA_Src selector encodings (branch target kind)
//   - ASSERT_N: asserted level of the sequencer's active-low strobes
// -----------------------------------------------------------------------------
package pc_unit_pkg;

    // Next-PC source selected when PC_Ld is asserted.
    localparam logic [1:0] PCSRC_BRANCH = 2'b00;
    localparam logic [1:0] PCSRC_RETURN = 2'b01;
    localparam logic [1:0] PCSRC_SRC1   = 2'b10;
    localparam logic [1:0] PCSRC_RSVD   = 2'b11;

    // Branch target kind for PCSRC_BRANCH.
    localparam logic BRA_SRC1 = 1'b0;   // absolute: Src1_Data
    localparam logic BRA_REL  = 1'b1;   // relative: PC + sext(IR_Offset)

    // All sequencer strobes are active-low.
    localparam logic ASSERT_N = 1'b0;

endpackage : pc_unit_pkg

// File: rtl/pc_unit_return_stack.sv
// -----------------------------------------------------------------------------
// return_stack
// Parameterised LIFO holding return addresses for JPL/RET.
//   Clk, Reset    : clock, synchronous active-low reset (clears pointer only)
//   clear         : synchronous pointer clear (PC_Rst path)
//   push, pop     : single-cycle requests; both together swap the top entry
//                   when non-empty, or behave as a plain push when empty
//   push_data     : value written on push / swap
//   top           : top-of-stack, forced to 0 when empty
//   depth         : entries in use
//   full, empty   : occupancy status
// A push while full (without pop) leaves the stack untouched; a pop while
// empty moves nothing. Flagging those cases is the caller's job.
// -----------------------------------------------------------------------------
module return_stack #(
    parameter int Width = 16,
    parameter int Depth = 4
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       clear,
    input  logic                       push,
    input  logic                       pop,
    input  logic [Width-1:0]           push_data,
    output logic [Width-1:0]           top,
    output logic [$clog2(Depth+1)-1:0] depth,
    output logic                       full,
    output logic                       empty
);

    localparam int PtrW = $clog2(Depth);
    localparam int CntW = $clog2(Depth+1);

    logic [Width-1:0] mem [Depth];
    logic [CntW-1:0]  sp;
    logic [PtrW-1:0]  wr_idx;
    logic [PtrW-1:0]  top_idx;
    logic             active;

    // Depth is a power of two, so the low pointer bits wrap to the right slot
    // when sp == Depth and top_idx = Depth-1.
    assign wr_idx  = sp[PtrW-1:0];
    assign top_idx = wr_idx - PtrW'(1);
    assign full    = (sp == CntW'(Depth));
    assign empty   = (sp == '0);
    assign depth   = sp;
    assign top     = empty ? '0 : mem[top_idx];
    assign active  = Reset && !clear;

    // NOTE: sequential state is always assigned with <= so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge Clk) begin
        if (!active) begin
            sp <= '0;
        end else if (push && pop) begin
            if (empty) sp <= CntW'(1);        // swap degenerates to a push
        end else if (push) begin
            if (!full) sp <= sp + CntW'(1);
        end else if (pop) begin
            if (!empty) sp <= sp - CntW'(1);
        end
    end

    // NOTE: the storage array has no reset; only the pointer is cleared and
    // the top output is gated, which keeps the array as plain RAM.
    always_ff @(posedge Clk) begin
        if (active && push) begin
            if (pop && !empty)  mem[top_idx] <= push_data;  // swap
            else if (!full)     mem[wr_idx]  <= push_data;
        end
    end

endmodule : return_stack

// File: rtl/pc_unit.sv
// -----------------------------------------------------------------------------
// pc_unit
// Program-counter stage driven by the sequence controller's strobes.
//   Clk, Reset  : clock, synchronous active-low reset of all state
//   PC_Rst      : active-low soft reset (PC, stack pointer, sticky flags)
//   PC_Inc      : active-low, PC <= PC + 1
//   PC_Ld       : active-low, PC <= target chosen by PC_Src (wins over PC_Inc)
//   PC_Src      : 00 branch, 01 return (pop), 10 Src1_Data, 11 reserved (hold)
//   STK_Ld      : active-low, push pre-edge PC onto the return stack
//   BRA_Src     : 1 relative (PC + sext(IR_Offset)), 0 absolute (Src1_Data)
//   IR_Offset   : branch offset field from the IR
//   Src1_Data   : register-file Source 1 read data
//   PC          : current fetch address
//   Return_Addr : top of return stack, 0 when empty
//   STK_Depth   : return-stack entries in use
//   STK_Ovf     : sticky, push attempted while full
//   STK_Unf     : sticky, pop attempted while empty
// -----------------------------------------------------------------------------
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int                    AddrWidth   = 16,
    parameter int                    OffsetWidth = 10,
    parameter int                    StackDepth  = 4,
    parameter logic [AddrWidth-1:0]  ResetVector = '0
) (
    input  logic                             Clk,
    input  logic                             Reset,
    input  logic                             PC_Rst,
    input  logic                             PC_Inc,
    input  logic                             PC_Ld,
    input  logic [1:0]                       PC_Src,
    input  logic                             STK_Ld,
    input  logic                             BRA_Src,
    input  logic [OffsetWidth-1:0]           IR_Offset,
    input  logic [AddrWidth-1:0]             Src1_Data,
    output logic [AddrWidth-1:0]             PC,
    output logic [AddrWidth-1:0]             Return_Addr,
    output logic [$clog2(StackDepth+1)-1:0]  STK_Depth,
    output logic                             STK_Ovf,
    output logic                             STK_Unf
);

    logic [AddrWidth-1:0] pc_q;
    logic [AddrWidth-1:0] pc_next;
    logic [AddrWidth-1:0] offset_sext;
    logic                 soft_rst;
    logic                 push_req;
    logic                 pop_req;
    logic                 stk_full;
    logic                 stk_empty;
    logic                 ovf_q;
    logic                 unf_q;

    assign soft_rst = (PC_Rst == ASSERT_N);
    // Soft reset outranks every strobe, so it also masks stack traffic.
    assign push_req = (STK_Ld == ASSERT_N) && !soft_rst;
    assign pop_req  = (PC_Ld == ASSERT_N) && (PC_Src == PCSRC_RETURN) && !soft_rst;

    assign offset_sext = {{(AddrWidth-OffsetWidth){IR_Offset[OffsetWidth-1]}}, IR_Offset};

    return_stack #(
        .Width (AddrWidth),
        .Depth (StackDepth)
    ) u_stack (
        .Clk       (Clk),
        .Reset     (Reset),
        .clear     (soft_rst),
        .push      (push_req),
        .pop       (pop_req),
        .push_data (pc_q),
        .top       (Return_Addr),
        .depth     (STK_Depth),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    // NOTE: pc_next gets a default before any branch so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        pc_next = pc_q;
        if (soft_rst) begin
            pc_next = ResetVector;
        end else if (PC_Ld == ASSERT_N) begin
            case (PC_Src)
                PCSRC_BRANCH: pc_next = (BRA_Src == BRA_REL) ? pc_q + offset_sext : Src1_Data;
                PCSRC_RETURN: pc_next = stk_empty ? pc_q : Return_Addr;
                PCSRC_SRC1:   pc_next = Src1_Data;
                default:      pc_next = pc_q;       // reserved: hold
            endcase
        end else if (PC_Inc == ASSERT_N) begin
            pc_next = pc_q + AddrWidth'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset || soft_rst) begin
            pc_q  <= ResetVector;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q <= pc_next;
            // A push together with a pop is a swap, never an overflow.
            if (push_req && stk_full && !pop_req) ovf_q <= 1'b1;
            if (pop_req && stk_empty)             unf_q <= 1'b1;
        end
    end

    assign PC      = pc_q;
    assign STK_Ovf = ovf_q;
    assign STK_Unf = unf_q;

endmodule : pc_unit

// File: tb/tb_pc_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_unit
// Directed bench for pc_unit. Each step queues the expected post-edge state,
// drives one clock edge, then pops and compares against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_pc_unit;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        PC_Rst;
    logic        PC_Inc;
    logic        PC_Ld;
    logic [1:0]  PC_Src;
    logic        STK_Ld;
    logic        BRA_Src;
    logic [9:0]  IR_Offset;
    logic [15:0] Src1_Data;
    logic [15:0] PC;
    logic [15:0] Return_Addr;
    logic [2:0]  STK_Depth;
    logic        STK_Ovf;
    logic        STK_Unf;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       tag;
        logic [15:0] pc;
        logic [15:0] ret;
        logic [2:0]  depth;
        logic        ovf;
        logic        unf;
    } exp_t;

    exp_t sb[$];

    pc_unit #(
        .AddrWidth   (16),
        .OffsetWidth (10),
        .StackDepth  (4),
        .ResetVector (16'h0000)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .PC_Rst      (PC_Rst),
        .PC_Inc      (PC_Inc),
        .PC_Ld       (PC_Ld),
        .PC_Src      (PC_Src),
        .STK_Ld      (STK_Ld),
        .BRA_Src     (BRA_Src),
        .IR_Offset   (IR_Offset),
        .Src1_Data   (Src1_Data),
        .PC          (PC),
        .Return_Addr (Return_Addr),
        .STK_Depth   (STK_Depth),
        .STK_Ovf     (STK_Ovf),
        .STK_Unf     (STK_Unf)
    );

    always #5 Clk = ~Clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_state(input string tag, input logic [15:0] pc, input logic [15:0] ret,
                                input logic [2:0] depth, input logic ovf, input logic unf);
        exp_t e;
        e.tag = tag; e.pc = pc; e.ret = ret; e.depth = depth; e.ovf = ovf; e.unf = unf;
        sb.push_back(e);
    endtask

    // Drive one edge's worth of inputs (called at a falling edge), let the
    // rising edge happen, return strobes to idle at the next falling edge and
    // compare the queued expectation there.
    task automatic step(input logic rst_n, input logic pc_rst, input logic inc, input logic ld,
                        input logic [1:0] src, input logic stk, input logic bra,
                        input logic [9:0] off, input logic [15:0] s1);
        exp_t e;
        Reset = rst_n; PC_Rst = pc_rst; PC_Inc = inc; PC_Ld = ld;
        PC_Src = src; STK_Ld = stk; BRA_Src = bra; IR_Offset = off; Src1_Data = s1;
        @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b1; PC_Rst = 1'b1; PC_Inc = 1'b1; PC_Ld = 1'b1; STK_Ld = 1'b1;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL scoreboard: observed empty queue expected an entry");
        end else begin
            e = sb.pop_front();
            check16({e.tag, ".pc"},    PC,                   e.pc);
            check16({e.tag, ".ret"},   Return_Addr,          e.ret);
            check16({e.tag, ".depth"}, {13'd0, STK_Depth},   {13'd0, e.depth});
            check16({e.tag, ".ovf"},   {15'd0, STK_Ovf},     {15'd0, e.ovf});
            check16({e.tag, ".unf"},   {15'd0, STK_Unf},     {15'd0, e.unf});
        end
    endtask

    // Shorthands: args are (rst_n, pc_rst, inc, ld, src, stk, bra, off, s1)
    task automatic do_reset();                expect_state("reset", 0, 0, 0, 0, 0); step(0,1,1,1,2'b00,1,0,0,0); endtask
    task automatic do_load(input logic [15:0] a); step(1,1,1,0,2'b10,1,0,0,a); endtask
    task automatic do_inc();                  step(1,1,0,1,2'b00,1,0,0,0); endtask
    task automatic do_jpl(input logic [15:0] a);  step(1,1,1,0,2'b10,0,0,0,a); endtask
    task automatic do_ret();                  step(1,1,1,0,2'b01,1,0,0,0); endtask
    task automatic do_soft_rst();             step(1,0,1,1,2'b00,1,0,0,0); endtask

    initial begin
        Reset = 1'b0; PC_Rst = 1'b1; PC_Inc = 1'b1; PC_Ld = 1'b1; PC_Src = 2'b00;
        STK_Ld = 1'b1; BRA_Src = 1'b0; IR_Offset = '0; Src1_Data = '0;
        @(negedge Clk);

        // Reset for two edges, then three increments.
        do_reset();
        do_reset();
        expect_state("inc1", 16'h0001, 0, 0, 0, 0); do_inc();
        expect_state("inc2", 16'h0002, 0, 0, 0, 0); do_inc();
        expect_state("inc3", 16'h0003, 0, 0, 0, 0); do_inc();

        // Increment wraps from all-ones.
        expect_state("ld_ffff", 16'hFFFF, 0, 0, 0, 0); do_load(16'hFFFF);
        expect_state("inc_wrap", 16'h0000, 0, 0, 0, 0); do_inc();

        // Relative branch with negative offset.
        expect_state("ld_0010a", 16'h0010, 0, 0, 0, 0); do_load(16'h0010);
        expect_state("bra_rel", 16'h000C, 0, 0, 0, 0); step(1,1,1,0,2'b00,1,1,10'h3FC,16'h0000);

        // Absolute branch from Src1_Data.
        expect_state("ld_0010b", 16'h0010, 0, 0, 0, 0); do_load(16'h0010);
        expect_state("bra_abs", 16'h0100, 0, 0, 0, 0); step(1,1,1,0,2'b00,1,0,10'h3FC,16'h0100);

        // PC_Ld outranks PC_Inc.
        expect_state("ld_over_inc", 16'h0040, 0, 0, 0, 0); step(1,1,0,0,2'b10,1,0,0,16'h0040);

        // JPL then RET.
        expect_state("ld_0021", 16'h0021, 0, 0, 0, 0); do_load(16'h0021);
        expect_state("jpl", 16'h0200, 16'h0021, 1, 0, 0); do_jpl(16'h0200);
        expect_state("ret", 16'h0021, 16'h0000, 0, 0, 0); do_ret();

        // Fill to overflow: fifth push is dropped, PC still loads.
        expect_state("ld_1000", 16'h1000, 0, 0, 0, 0); do_load(16'h1000);
        expect_state("push1", 16'h1001, 16'h1000, 1, 0, 0); do_jpl(16'h1001);
        expect_state("push2", 16'h1002, 16'h1001, 2, 0, 0); do_jpl(16'h1002);
        expect_state("push3", 16'h1003, 16'h1002, 3, 0, 0); do_jpl(16'h1003);
        expect_state("push4", 16'h1004, 16'h1003, 4, 0, 0); do_jpl(16'h1004);
        expect_state("push5_ovf", 16'h1005, 16'h1003, 4, 1, 0); do_jpl(16'h1005);

        // Drain past empty: fifth pop holds PC and sets underflow.
        expect_state("pop1", 16'h1003, 16'h1002, 3, 1, 0); do_ret();
        expect_state("pop2", 16'h1002, 16'h1001, 2, 1, 0); do_ret();
        expect_state("pop3", 16'h1001, 16'h1000, 1, 1, 0); do_ret();
        expect_state("pop4", 16'h1000, 16'h0000, 0, 1, 0); do_ret();
        expect_state("pop5_unf", 16'h1000, 16'h0000, 0, 1, 1); do_ret();

        // Soft reset clears PC, stack pointer and sticky flags.
        expect_state("pc_rst", 16'h0000, 0, 0, 0, 0); do_soft_rst();

        // Swap with depth 1.
        expect_state("ld_0050", 16'h0050, 0, 0, 0, 0); do_load(16'h0050);
        expect_state("push_only", 16'h0050, 16'h0050, 1, 0, 0); step(1,1,1,1,2'b00,0,0,0,0);
        expect_state("ld_0080", 16'h0080, 16'h0050, 1, 0, 0); do_load(16'h0080);
        expect_state("swap", 16'h0050, 16'h0080, 1, 0, 0); step(1,1,1,0,2'b01,0,0,0,0);

        // Push + pop on an empty stack: underflow, PC holds, push happens.
        expect_state("pc_rst2", 16'h0000, 0, 0, 0, 0); do_soft_rst();
        expect_state("ld_0033", 16'h0033, 0, 0, 0, 0); do_load(16'h0033);
        expect_state("swap_empty", 16'h0033, 16'h0033, 1, 0, 1); step(1,1,1,0,2'b01,0,0,0,0);

        // Reserved source: hold, no stack effect.
        expect_state("rsvd", 16'h0033, 16'h0033, 1, 0, 1); step(1,1,1,0,2'b11,1,0,0,16'h7777);

        // Hard reset wins over concurrent load and push.
        expect_state("reset_ovr", 16'h0000, 0, 0, 0, 0); step(0,1,1,0,2'b10,0,0,0,16'h1234);
        expect_state("post_reset", 16'h0000, 0, 0, 0, 0); step(1,1,1,1,2'b00,1,0,0,0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pc_unit

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Program-counter stage directly downstream of the sequence controller.
- Consumes its PC_Rst, PC_Inc, PC_Ld, PC_Src, STK_Ld and BRA_Src strobes.
- Produces the fetch address (PC) and holds a hardware return-address stack for JPL/RET.
- Branch targets come from the IR offset field or from register-file Source 1.

Parameters:
AddrWidth, 16, width of PC, stack entries and Src1_Data
OffsetWidth, 10, width of IR branch offset, sign-extended for relative branches
StackDepth, 4, number of return-address entries (power of two, >=2)
ResetVector, 0, PC value after Reset or PC_Rst

Ports:
Clk  in  1  clock, all state changes on rising edge
Reset  in  1  synchronous, active-low; clears all state
PC_Rst  in  1  active-low; PC<=ResetVector, stack emptied, sticky flags cleared
PC_Inc  in  1  active-low; PC<=PC+1
PC_Ld  in  1  active-low; PC<=selected target
PC_Src  in  2  00 branch target, 01 return address (pop), 10 Src1_Data, 11 reserved
STK_Ld  in  1  active-low; push current PC onto return stack
BRA_Src  in  1  1 relative (PC+sext(IR_Offset)), 0 absolute (Src1_Data)
IR_Offset  in  OffsetWidth  IR[OffsetWidth-1:0]
Src1_Data  in  AddrWidth  register-file Source 1 read data
PC  out  AddrWidth  current fetch address
Return_Addr  out  AddrWidth  top of stack; 0 when empty
STK_Depth  out  clog2(StackDepth+1)  entries in use
STK_Ovf  out  1  sticky, push attempted while full
STK_Unf  out  1  sticky, pop attempted while empty

Behaviour:
- Reset: Reset=0 on an edge sets PC=ResetVector, STK_Depth=0, STK_Ovf=0 and STK_Unf=0. Return_Addr reads 0. Reset overrides every other input.
- PC update priority per edge: Reset > PC_Rst > PC_Ld > PC_Inc > hold.
- PC_Rst=0 gives the same effect as Reset on PC, stack and flags.
- Next-PC mux is combinational; the PC register has 1-cycle latency from strobe to new value.
- Branch target, PC_Src=00:
  - BRA_Src=1: PC + sign-extend(IR_Offset), modulo 2^AddrWidth. PC here is the already-incremented value (sequencer bumps PC before Decode).
  - BRA_Src=0: Src1_Data.
- PC_Src=10: PC<=Src1_Data.
- PC_Src=11 with PC_Ld=0: PC holds; no stack effect.
- PC_Inc: wraps from all-ones to 0.
- Push (STK_Ld=0, not resetting):
  - Write PC's pre-edge value to stack[SP]; SP<=SP+1. The link is the address of the instruction after JPL.
  - If full: stack unchanged, STK_Ovf<=1, PC update still proceeds.
- Pop (PC_Ld=0 and PC_Src=01):
  - Non-empty: PC<=stack[SP-1]; SP<=SP-1.
  - Empty: PC holds, STK_Unf<=1.
- Simultaneous push and pop, same edge:
  - Non-empty: PC<=old top, top<=pre-edge PC, depth unchanged (swap).
  - Empty: STK_Unf<=1, PC holds, push performed (depth becomes 1).
- STK_Ld=0 with a non-pop PC_Ld is the JPL case: push old PC and load new target on the same edge.
- Stack storage is not cleared on reset. Only SP is reset; Return_Addr is gated to 0 when empty.
- Sticky flags clear only on Reset or PC_Rst.
- Strobes held low for several cycles act once per edge. Each edge with PC_Inc=0 increments again; the sequencer guarantees single-cycle strobes.

Decomposition:
- Shared package holds:
  - PC_Src encodings: PCSRC_BRANCH=2'b00, PCSRC_RETURN=2'b01, PCSRC_SRC1=2'b10, PCSRC_RSVD=2'b11.
  - BRA_Src encodings: BRA_SRC1=0, BRA_REL=1.
  - Active-low strobe level constant ASSERT_N=1'b0.
- One sub-module, return_stack:
  - Parameterised LIFO with push, pop, swap, full/empty, depth and top-of-stack output.
  - pc_unit owns the PC register, next-PC mux and sticky flags.

Test Plan:
- Reset=0 for 2 edges, then PC_Inc=0 for 3 single-cycle pulses -> PC 0,1,2,3; STK_Depth=0; flags 0.
- PC at 16'hFFFF, PC_Inc=0 -> PC=16'h0000.
- PC=16'h0010, PC_Ld=0, PC_Src=00, BRA_Src=1, IR_Offset=10'h3FC (-4) -> PC=16'h000C.
- Same setup with BRA_Src=0, Src1_Data=16'h0100 -> PC=16'h0100.
- JPL then RET:
  - PC=16'h0021, STK_Ld=0, PC_Ld=0, PC_Src=10, Src1_Data=16'h0200 -> PC=16'h0200, Return_Addr=16'h0021, depth 1.
  - Then PC_Ld=0, PC_Src=01 -> PC=16'h0021, depth 0.
- 5 pushes with StackDepth=4 -> depth 4, STK_Ovf=1, top = 4th pushed value. Then 5 pops -> 4 correct returns, 5th holds PC and STK_Unf=1. Then PC_Rst=0 -> PC=0, depth 0, flags 0.
- Simultaneous push and pop, depth 1, top=16'h0050, PC=16'h0080 -> PC=16'h0050, Return_Addr=16'h0080, depth 1.
- Reset=0 asserted concurrently with PC_Ld=0 and STK_Ld=0 -> PC=ResetVector, depth 0, no push recorded.
